pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program counter for the RISC-V core's fetch stage, the successor to the single-width counter. Adds a configurable step (word or byte addressing), a programmable reset address, a trap vector and an internal return-address stack (RAS) for call/return, with status flags. Sits between the control unit (which decodes run/jump/call/ret/trap) and instruction memory (which consumes `pc`).

## Interface

- `PC_WIDTH`, 16, width of the program counter and all addresses
- `PC_STEP`, 1, sequential increment (1 = word-addressed, 4 = byte-addressed)
- `RESET_ADDR`, 0, value loaded into `pc` on reset
- `TRAP_ADDR`, 16'h0010, trap vector, truncated to `PC_WIDTH`
- `RAS_DEPTH`, 4, return-address stack entries, >= 1
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `run`  in  1  advance enable; 0 holds `pc` and the stack (trap excepted)
- `jump`  in  1  load `jump_address`
- `call`  in  1  load `jump_address` and push return address `pc + PC_STEP`
- `ret`  in  1  pop stack top into `pc`
- `trap`  in  1  load `TRAP_ADDR`
- `jump_address`  in  PC_WIDTH  target for jump/call
- `pc`  out  PC_WIDTH  current program counter (registered)
- `ras_count`  out  $clog2(RAS_DEPTH+1)  valid stack entries, 0..RAS_DEPTH
- `ras_empty`  out  1  `ras_count == 0`
- `ras_full`  out  1  `ras_count == RAS_DEPTH`
- `ras_overflow`  out  1  sticky: a call occurred while full
- `ras_underflow`  out  1  sticky: a ret occurred while empty

## Operation

- Next-PC priority, highest first: `trap` > `ret` > `call` > `jump` > sequential. Exactly one action per cycle; lower-priority requests in the same cycle are dropped.
- `trap`: acts regardless of `run`; `pc <= TRAP_ADDR`; stack untouched.
- With `run = 0` and no `trap`: `pc`, stack and flags hold.
- With `run = 1`:
  - `ret`, stack non-empty: `pc <=` top entry; pointer decrements; `ras_count - 1`.
  - `ret`, stack empty: `pc <= pc + PC_STEP`; `ras_underflow <= 1`; count stays 0.
  - `call`, not full: `pc <= jump_address`; push `pc + PC_STEP`; `ras_count + 1`.
  - `call`, full: circular overwrite of the oldest entry; top becomes the new return address; count stays `RAS_DEPTH`; `ras_overflow <= 1`.
  - `jump`: `pc <= jump_address`.
  - None: `pc <= pc + PC_STEP`.
- Stack: circular buffer of `RAS_DEPTH` x `PC_WIDTH` registers plus a top pointer (mod `RAS_DEPTH`) and a count. The top entry is read combinationally for ret.
- Arithmetic: all additions are modulo 2^`PC_WIDTH`. `pc + PC_STEP` wraps, e.g. 16'hFFFF + 1 = 16'h0000 for both the sequential path and the pushed return address.
- Sticky flags clear only on reset.

## Timing

- Reset (`rst_n` low, asynchronous, takes effect immediately):
  - `pc = RESET_ADDR`, `ras_count = 0`, `ras_empty = 1`, `ras_full = 0`, `ras_overflow = 0`, `ras_underflow = 0`.
  - Stack contents are don't-care.
- Reset asserted mid-operation discards any pending action and stack contents. Release is sampled on the next rising edge.
- Latency: one cycle. Inputs sampled at edge N give `pc`, count and flags valid after edge N.
- `ras_empty` and `ras_full` are decoded from the registered count and never lag it.
- A call followed by a ret in the next cycle returns to `call_pc + PC_STEP`; no bubble is required.
- `call` and `ret` asserted together: ret wins (pop only, no push).

## Test plan

- Reset/sequential: `RESET_ADDR = 0`, `PC_STEP = 4`, `run = 1` for 3 cycles -> `pc` = 0, 4, 8, 12. Assert `rst_n = 0` between edges -> `pc = 0` immediately. Release; `run = 0` for 2 cycles -> `pc` holds.
- Call/return nesting: from `pc = 16'h0002`, call to 16'h0100, then call to 16'h0200 -> `ras_count = 2`. Ret -> `pc = 16'h0101`, count 1. Ret -> `pc = 16'h0003`, count 0, `ras_empty = 1`, no flags set.
- Overflow: `RAS_DEPTH = 4`, 5 consecutive calls from pcs A..E -> `ras_full = 1`, `ras_overflow = 1`, count 4. Four rets return E+1, D+1, C+1, B+1; a fifth ret -> `pc` = previous + 1 and `ras_underflow = 1`.
- Priority: `trap`, `ret`, `call` and `jump` asserted together with `run = 0` -> `pc = TRAP_ADDR`, count unchanged. Same cycle with `trap = 0`, `run = 1`, stack {16'h0050} -> `pc = 16'h0050`, no push.
- Wrap-around: `PC_WIDTH = 16`, `pc = 16'hFFFF`, `PC_STEP = 1`. Call to 16'h0040 -> pushed address 16'h0000; ret -> `pc = 16'h0000`. Sequential step from 16'hFFFF -> 16'h0000.

Source files
------------

// File: rtl/pc_unit.sv
// Fetch-stage program counter with a configurable step, a trap vector and a
// circular return-address stack that reports overflow and underflow.
module pc_unit #(
    parameter int                  PC_WIDTH   = 16,
    parameter int                  PC_STEP    = 1,
    parameter logic [PC_WIDTH-1:0] RESET_ADDR = '0,
    parameter logic [PC_WIDTH-1:0] TRAP_ADDR  = PC_WIDTH'(16'h0010),
    parameter int                  RAS_DEPTH  = 4,
    localparam int                 CW         = $clog2(RAS_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                jump,
    input  logic                call,
    input  logic                ret,
    input  logic                trap,
    input  logic [PC_WIDTH-1:0] jump_address,
    output logic [PC_WIDTH-1:0] pc,
    output logic [CW-1:0]       ras_count,
    output logic                ras_empty,
    output logic                ras_full,
    output logic                ras_overflow,
    output logic                ras_underflow
);

    localparam int                  PW         = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PW-1:0]       TOP_LAST   = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0]       COUNT_FULL = CW'(RAS_DEPTH);
    localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(PC_STEP);

    logic [PC_WIDTH-1:0] pc_reg, pc_next;
    logic [PW-1:0]       top_reg, top_next;
    logic [CW-1:0]       count_reg, count_next;
    logic                overflow_reg, overflow_next;
    logic                underflow_reg, underflow_next;
    logic                push;
    logic [PC_WIDTH-1:0] seq_pc;
    logic [PC_WIDTH-1:0] top_entry;
    logic [PC_WIDTH-1:0] stack [RAS_DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == TOP_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? TOP_LAST : p - 1'b1;
    endfunction

    // Sequential address doubles as the pushed return address; wraps modulo 2^PC_WIDTH.
    assign seq_pc    = pc_reg + STEP;
    assign top_entry = stack[top_reg];

    always_comb begin
        pc_next        = pc_reg;
        top_next       = top_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        push           = 1'b0;
        if (trap) begin
            pc_next = TRAP_ADDR;
        end else if (run) begin
            if (ret) begin
                if (count_reg != '0) begin
                    pc_next    = top_entry;
                    top_next   = ptr_dec(top_reg);
                    count_next = count_reg - 1'b1;
                end else begin
                    pc_next        = seq_pc;
                    underflow_next = 1'b1;
                end
            end else if (call) begin
                pc_next  = jump_address;
                push     = 1'b1;
                // When full, the slot after the top is the oldest entry, so it is overwritten.
                top_next = ptr_inc(top_reg);
                if (count_reg == COUNT_FULL) begin
                    overflow_next = 1'b1;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end else if (jump) begin
                pc_next = jump_address;
            end else begin
                pc_next = seq_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg        <= RESET_ADDR;
            top_reg       <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            pc_reg        <= pc_next;
            top_reg       <= top_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Stack contents carry no reset; validity is tracked entirely by count_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[top_next] <= seq_pc;
        end
    end

    assign pc            = pc_reg;
    assign ras_count     = count_reg;
    assign ras_empty     = (count_reg == '0);
    assign ras_full      = (count_reg == COUNT_FULL);
    assign ras_overflow  = overflow_reg;
    assign ras_underflow = underflow_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Drives two pc_unit instances (step 1 and step 4) with shared stimulus and
// checks them against a list-based call-stack model through a scoreboard queue.
module tb_pc_unit;

    localparam int DEPTH = 4;
    localparam logic [15:0] TRAP = 16'h0010;
    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0, trap = 1'b0;
    logic [15:0] jump_address = '0;

    logic [15:0] pc_a, pc_b;
    logic [2:0]  cnt_a, cnt_b;
    logic        emp_a, emp_b, full_a, full_b, ovf_a, ovf_b, unf_a, unf_b;

    pc_unit #(.PC_WIDTH(16), .PC_STEP(1), .RESET_ADDR(RST_PC), .TRAP_ADDR(TRAP), .RAS_DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst_n(rst_n), .run(run), .jump(jump), .call(call), .ret(ret), .trap(trap),
        .jump_address(jump_address), .pc(pc_a), .ras_count(cnt_a), .ras_empty(emp_a),
        .ras_full(full_a), .ras_overflow(ovf_a), .ras_underflow(unf_a));

    pc_unit #(.PC_WIDTH(16), .PC_STEP(4), .RESET_ADDR(RST_PC), .TRAP_ADDR(TRAP), .RAS_DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst_n(rst_n), .run(run), .jump(jump), .call(call), .ret(ret), .trap(trap),
        .jump_address(jump_address), .pc(pc_b), .ras_count(cnt_b), .ras_empty(emp_b),
        .ras_full(full_b), .ras_overflow(ovf_b), .ras_underflow(unf_b));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0][15:0] pc;
        int               cnt [2];
        logic [1:0]       ovf;
        logic [1:0]       unf;
    } exp_t;

    exp_t sb [$];
    event item_ev;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_txn = 0;

    // Reference model: stack kept as an ordered list, oldest at index 0.
    logic [15:0] m_pc  [2];
    logic [15:0] m_stk [2][DEPTH];
    int          m_cnt [2];
    logic        m_ovf [2];
    logic        m_unf [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pc[d] = RST_PC; m_cnt[d] = 0; m_ovf[d] = 1'b0; m_unf[d] = 1'b0;
        end
    endtask

    task automatic model_update();
        logic [15:0] st;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            st = (d == 0) ? 16'd1 : 16'd4;
            if (trap) begin
                m_pc[d] = TRAP;
            end else if (run) begin
                if (ret) begin
                    if (m_cnt[d] > 0) begin
                        m_pc[d] = m_stk[d][m_cnt[d]-1];
                        m_cnt[d]--;
                    end else begin
                        m_pc[d] = m_pc[d] + st;
                        m_unf[d] = 1'b1;
                    end
                end else if (call) begin
                    if (m_cnt[d] == DEPTH) begin
                        for (int i = 0; i < DEPTH - 1; i++) m_stk[d][i] = m_stk[d][i+1];
                        m_stk[d][DEPTH-1] = m_pc[d] + st;
                        m_ovf[d] = 1'b1;
                    end else begin
                        m_stk[d][m_cnt[d]] = m_pc[d] + st;
                        m_cnt[d]++;
                    end
                    m_pc[d] = jump_address;
                end else if (jump) begin
                    m_pc[d] = jump_address;
                end else begin
                    m_pc[d] = m_pc[d] + st;
                end
            end
        end
    endtask

    task automatic push_expected();
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            e.pc[d] = m_pc[d]; e.cnt[d] = m_cnt[d]; e.ovf[d] = m_ovf[d]; e.unf[d] = m_unf[d];
        end
        sb.push_back(e);
        -> item_ev;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        push_expected();
        #2;
    endtask

    task automatic step(input bit r, input bit j, input bit c, input bit rt, input bit tr,
                        input logic [15:0] a);
        run = r; jump = j; call = c; ret = rt; trap = tr; jump_address = a;
        tick();
    endtask

    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        model_reset();
        push_expected();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk(input string nm, input int d, input int act, input int exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s dut%0d txn %0d: got %0h expected %0h", nm, d, n_txn, act, exp_v);
        end
    endtask

    // Monitor: every queued expectation is compared 1 time unit after it was issued.
    initial begin
        exp_t e;
        forever begin
            @(item_ev);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_txn++;
                chk("pc",        0, int'(pc_a),   int'(e.pc[0]));
                chk("pc",        1, int'(pc_b),   int'(e.pc[1]));
                chk("ras_count", 0, int'(cnt_a),  e.cnt[0]);
                chk("ras_count", 1, int'(cnt_b),  e.cnt[1]);
                chk("ras_empty", 0, int'(emp_a),  int'(e.cnt[0] == 0));
                chk("ras_empty", 1, int'(emp_b),  int'(e.cnt[1] == 0));
                chk("ras_full",  0, int'(full_a), int'(e.cnt[0] == DEPTH));
                chk("ras_full",  1, int'(full_b), int'(e.cnt[1] == DEPTH));
                chk("overflow",  0, int'(ovf_a),  int'(e.ovf[0]));
                chk("overflow",  1, int'(ovf_b),  int'(e.ovf[1]));
                chk("underflow", 0, int'(unf_a),  int'(e.unf[0]));
                chk("underflow", 1, int'(unf_b),  int'(e.unf[1]));
                $display("txn %0d rst_n=%0b pc=%h/%h cnt=%0d/%0d", n_txn, rst_n, pc_a, pc_b, cnt_a, cnt_b);
            end
        end
    end

    initial begin
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;

        // Sequential stepping, asynchronous reset mid-run, then hold
        repeat (3) step(1, 0, 0, 0, 0, 16'h0000);
        reset_pulse();
        repeat (2) step(0, 0, 0, 0, 0, 16'h0000);

        // Nested call/return
        step(1, 1, 0, 0, 0, 16'h0002);
        step(1, 0, 1, 0, 0, 16'h0100);
        step(1, 0, 1, 0, 0, 16'h0200);
        step(1, 0, 0, 1, 0, 16'h0000);
        step(1, 0, 0, 1, 0, 16'h0000);

        // Overflow by five calls, then five returns ending in underflow
        step(1, 0, 1, 0, 0, 16'h1000);
        step(1, 0, 1, 0, 0, 16'h2000);
        step(1, 0, 1, 0, 0, 16'h3000);
        step(1, 0, 1, 0, 0, 16'h4000);
        step(1, 0, 1, 0, 0, 16'h5000);
        repeat (5) step(1, 0, 0, 1, 0, 16'h0000);

        // Priority: trap ignores run; ret beats call and jump
        reset_pulse();
        step(1, 1, 0, 0, 0, 16'h004F);
        step(1, 0, 1, 0, 0, 16'h0300);
        step(0, 1, 1, 1, 1, 16'h0777);
        step(1, 1, 1, 1, 0, 16'h0777);

        // Wrap-around of return address and sequential path
        step(1, 1, 0, 0, 0, 16'hFFFF);
        step(1, 0, 1, 0, 0, 16'h0040);
        step(1, 0, 0, 1, 0, 16'h0000);
        step(1, 1, 0, 0, 0, 16'hFFFF);
        step(1, 0, 0, 0, 0, 16'h0000);
        step(1, 0, 1, 1, 0, 16'h0123);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            if ($urandom_range(0, 79) == 0) begin
                reset_pulse();
            end else begin
                a = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
                step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 20,
                     $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
                     $urandom_range(0, 19) == 0, a);
            end
        end

        #10;
        chk("drain", 0, sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
